// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the off-chip 16-bit asynchronous SRAM.
// Record-path writes and playback-path reads share the pins via a fixed-length access FSM.
module sram_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              CLK50,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE,
  output logic              SRAM_OE,
  output logic              SRAM_CE,
  output logic              SRAM_UB,
  output logic              SRAM_LB
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_param
    $error("sram_arbiter: ACCESS_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_END,
    R_ACCESS,
    R_END
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              last_grant_wr, last_grant_wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              grant_wr, grant_rd;
  logic              dq_oe, dq_oe_nxt;
  logic              we_nxt, oe_nxt, ack_nxt, vld_nxt, busy_nxt;

  // The data bus is only ever driven while a write sequence owns it.
  assign SRAM_DQ = dq_oe ? wdata : {DATA_W{1'bz}};

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    last_grant_wr_nxt = last_grant_wr;
    addr_nxt          = SRAM_ADDR;
    wdata_nxt         = wdata;
    rdata_nxt         = rd_data;
    grant_wr          = 1'b0;
    grant_rd          = 1'b0;

    case (state)
      IDLE: begin
        // On contention the requester that did not win last time gets the bus.
        grant_wr = wr_req && (!rd_req || !last_grant_wr);
        grant_rd = rd_req && (!wr_req || last_grant_wr);
        if (grant_wr) begin
          state_nxt         = W_SETUP;
          addr_nxt          = wr_addr;
          wdata_nxt         = wr_data;
          last_grant_wr_nxt = 1'b1;
        end else if (grant_rd) begin
          state_nxt         = R_ACCESS;
          addr_nxt          = rd_addr;
          cnt_nxt           = CNT_LOAD;
          last_grant_wr_nxt = 1'b0;
        end
      end
      W_SETUP: begin
        state_nxt = W_PULSE;
        cnt_nxt   = CNT_LOAD;
      end
      W_PULSE: begin
        if (cnt == 4'd0) state_nxt = W_END;
        else             cnt_nxt   = cnt - 4'd1;
      end
      W_END: begin
        state_nxt = IDLE;
      end
      R_ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = R_END;
          rdata_nxt = SRAM_DQ;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      R_END: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Pin-level outputs are registered, so they are decoded from the state being entered.
    we_nxt    = (state_nxt != W_PULSE);
    oe_nxt    = (state_nxt != R_ACCESS);
    dq_oe_nxt = (state_nxt == W_SETUP) || (state_nxt == W_PULSE) || (state_nxt == W_END);
    ack_nxt   = (state_nxt == W_END);
    vld_nxt   = (state_nxt == R_END);
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      last_grant_wr <= 1'b0;
      SRAM_ADDR     <= '0;
      wdata         <= '0;
      rd_data       <= '0;
      dq_oe         <= 1'b0;
      SRAM_WE       <= 1'b1;
      SRAM_OE       <= 1'b1;
      SRAM_CE       <= 1'b1;
      SRAM_UB       <= 1'b1;
      SRAM_LB       <= 1'b1;
      wr_ack        <= 1'b0;
      rd_valid      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      last_grant_wr <= last_grant_wr_nxt;
      SRAM_ADDR     <= addr_nxt;
      wdata         <= wdata_nxt;
      rd_data       <= rdata_nxt;
      dq_oe         <= dq_oe_nxt;
      SRAM_WE       <= we_nxt;
      SRAM_OE       <= oe_nxt;
      SRAM_CE       <= 1'b0;
      SRAM_UB       <= 1'b0;
      SRAM_LB       <= 1'b0;
      wr_ack        <= ack_nxt;
      rd_valid      <= vld_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table-driven accesses against an SRAM model, scoreboard on ack/valid,
// contention, reset mid-write and an ACCESS_CYCLES sweep on two extra instances.
module tb_sram_arbiter;

  logic        CLK50 = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [17:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] sram_dq;
  logic        SRAM_WE, SRAM_OE, SRAM_CE, SRAM_UB, SRAM_LB;

  always #10 CLK50 = ~CLK50;

  sram_arbiter #(.ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(2)) dut (
    .CLK50(CLK50), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(sram_dq),
    .SRAM_WE(SRAM_WE), .SRAM_OE(SRAM_OE), .SRAM_CE(SRAM_CE),
    .SRAM_UB(SRAM_UB), .SRAM_LB(SRAM_LB)
  );

  // Asynchronous SRAM model
  logic [15:0] mem [262144];
  assign sram_dq = (!SRAM_OE) ? mem[SRAM_ADDR] : 16'hzzzz;
  always @(posedge CLK50) if (!SRAM_WE) mem[SRAM_ADDR] <= sram_dq;

  // Sweep instances
  logic sw_wr_req [2];
  logic sw_rd_req [2];
  logic sw_ack [2];
  logic sw_vld [2];
  logic sw_we [2];
  logic sw_oe [2];
  for (genvar g = 0; g < 2; g++) begin : g_sw
    wire  [15:0] dq;
    logic [15:0] rdat;
    logic [17:0] addr;
    logic        bsy, ce, ub, lb;
    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(g == 0 ? 1 : 15)) u_sw (
      .CLK50(CLK50), .reset(reset),
      .wr_req(sw_wr_req[g]), .wr_addr(18'h00055), .wr_data(16'h00AA), .wr_ack(sw_ack[g]),
      .rd_req(sw_rd_req[g]), .rd_addr(18'h00055), .rd_data(rdat), .rd_valid(sw_vld[g]),
      .busy(bsy), .SRAM_ADDR(addr), .SRAM_DQ(dq),
      .SRAM_WE(sw_we[g]), .SRAM_OE(sw_oe[g]), .SRAM_CE(ce), .SRAM_UB(ub), .SRAM_LB(lb)
    );
  end

  int checks = 0;
  int failures = 0;
  int inv_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [15:0] data;
  } sb_t;
  sb_t sb[$];

  // Scoreboard and bus invariants
  always @(negedge CLK50) begin
    sb_t e;
    if (!SRAM_WE && !SRAM_OE) inv_bad++;
    if (dut.dq_oe && !SRAM_OE) inv_bad++;
    if (wr_ack || rd_valid) begin
      check("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_kind", 32'(wr_ack), 32'(e.is_wr));
        check("sb_addr", 32'(SRAM_ADDR), 32'(e.addr));
        if (!e.is_wr) check("sb_rdata", 32'(rd_data), 32'(e.data));
      end
    end
  end

  task automatic do_access(input bit is_wr, input logic [17:0] a, input logic [15:0] d,
                           output int lat, output int we_low, output int oe_low,
                           output int busy_n, output int dq_n, output int dq_bad);
    bit done = 1'b0;
    lat = 0; we_low = 0; oe_low = 0; busy_n = 0; dq_n = 0; dq_bad = 0;
    @(negedge CLK50);
    if (is_wr) begin
      wr_addr = a; wr_data = d; wr_req = 1'b1;
    end else begin
      rd_addr = a; rd_req = 1'b1;
    end
    sb.push_back('{is_wr, a, d});
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge CLK50);
      if (!SRAM_WE) we_low++;
      if (!SRAM_OE) oe_low++;
      if (busy) busy_n++;
      if (dut.dq_oe) dq_n++;
      if (dut.dq_oe && sram_dq != d) dq_bad++;
      if (is_wr ? wr_ack : rd_valid) begin
        lat = k; done = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      end
    end
    if (!done) begin
      check("access_timeout", 32'(done), 32'd1);
      wr_req = 1'b0; rd_req = 1'b0;
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [15:0] data;
    int          exp_lat;
    int          exp_we;
    int          exp_oe;
    int          exp_busy;
    int          exp_dq;
  } vec_t;
  vec_t vecs [18];

  initial begin
    logic [17:0] wb_addr [8];
    int cont_exp_k [4];
    bit cont_exp_w [4];
    int sw_ac [2];
    int ev_k [$];
    bit ev_w [$];
    int lat, we_low, oe_low, busy_n, dq_n, dq_bad, acks;
    int sw_lat [2];
    int sw_low [2];
    bit sw_done [2];

    wb_addr = '{18'h00000, 18'h00001, 18'h00155, 18'h002AA,
                18'h1FFFF, 18'h20000, 18'h3FFFE, 18'h12345};
    cont_exp_k = '{4, 8, 13, 17};
    cont_exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    sw_ac = '{1, 15};
    vecs[0] = '{1'b1, 18'h00123, 16'hBEEF, 4, 2, 0, 4, 4};
    vecs[1] = '{1'b0, 18'h3FFFF, 16'h5A5A, 3, 0, 2, 3, 0};
    for (int i = 0; i < 8; i++) begin
      vecs[2 + i]  = '{1'b1, wb_addr[i], wb_addr[i][15:0] ^ 16'hFFFF, 4, 2, 0, 4, 4};
      vecs[10 + i] = '{1'b0, wb_addr[i], wb_addr[i][15:0] ^ 16'hFFFF, 3, 0, 2, 3, 0};
    end
    for (int i = 0; i < 2; i++) begin
      sw_wr_req[i] = 1'b0; sw_rd_req[i] = 1'b0;
    end
    mem[18'h3FFFF] = 16'h5A5A;

    // Reset values
    @(negedge CLK50);
    check("rst_we", 32'(SRAM_WE), 32'd1);
    check("rst_oe", 32'(SRAM_OE), 32'd1);
    check("rst_ce_ub_lb", 32'({SRAM_CE, SRAM_UB, SRAM_LB}), 32'h7);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_ack_vld_busy", 32'({wr_ack, rd_valid, busy}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_dq_oe", 32'(dut.dq_oe), 32'd0);

    // Contention: both requests held from reset
    wr_addr = 18'h00ABC; wr_data = 16'h1234; wr_req = 1'b1;
    rd_addr = 18'h3FFFF; rd_req = 1'b1;
    sb.push_back('{1'b1, 18'h00ABC, 16'h1234});
    sb.push_back('{1'b0, 18'h3FFFF, 16'h5A5A});
    sb.push_back('{1'b1, 18'h00ABC, 16'h1234});
    sb.push_back('{1'b0, 18'h3FFFF, 16'h5A5A});
    @(negedge CLK50);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK50);
      if (k == 1) check("ce_ub_lb_active", 32'({SRAM_CE, SRAM_UB, SRAM_LB}), 32'h0);
      if (wr_ack || rd_valid) begin
        ev_k.push_back(k);
        ev_w.push_back(wr_ack);
        if (ev_k.size() == 4) begin
          wr_req = 1'b0; rd_req = 1'b0;
          break;
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("cont_events", 32'(ev_k.size()), 32'd4);
    for (int i = 0; i < ev_k.size() && i < 4; i++) begin
      check("cont_cycle", 32'(ev_k[i]), 32'(cont_exp_k[i]));
      check("cont_kind", 32'(ev_w[i]), 32'(cont_exp_w[i]));
    end

    // Table-driven single accesses: write, read, 8 writes, 8 readbacks
    for (int i = 0; i < 18; i++) begin
      do_access(vecs[i].is_wr, vecs[i].addr, vecs[i].data, lat, we_low, oe_low, busy_n, dq_n, dq_bad);
      check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
      check("vec_we_low", 32'(we_low), 32'(vecs[i].exp_we));
      check("vec_oe_low", 32'(oe_low), 32'(vecs[i].exp_oe));
      check("vec_busy", 32'(busy_n), 32'(vecs[i].exp_busy));
      check("vec_dq_driven", 32'(dq_n), 32'(vecs[i].exp_dq));
      check("vec_dq_value", 32'(dq_bad), 32'd0);
    end

    // rd_data holds across idle cycles and an unrelated write
    repeat (3) @(negedge CLK50);
    check("rd_hold_idle", 32'(rd_data), 32'(vecs[17].data));
    do_access(1'b1, 18'h00999, 16'hC0DE, lat, we_low, oe_low, busy_n, dq_n, dq_bad);
    check("rd_hold_write", 32'(rd_data), 32'(vecs[17].data));

    // Reset in the middle of W_PULSE
    @(negedge CLK50);
    wr_addr = 18'h00777; wr_data = 16'h7777; wr_req = 1'b1;
    @(negedge CLK50);
    @(negedge CLK50);
    check("mid_we_low", 32'(SRAM_WE), 32'd0);
    reset = 1'b1; wr_req = 1'b0;
    #1;
    check("mid_rst_we", 32'(SRAM_WE), 32'd1);
    check("mid_rst_dq_z", 32'(dut.dq_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK50);
      if (k == 2) reset = 1'b0;
      if (wr_ack) acks++;
    end
    check("mid_rst_no_ack", 32'(acks), 32'd0);
    do_access(1'b1, 18'h00777, 16'h4242, lat, we_low, oe_low, busy_n, dq_n, dq_bad);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_we_low", 32'(we_low), 32'd2);
    do_access(1'b0, 18'h00777, 16'h4242, lat, we_low, oe_low, busy_n, dq_n, dq_bad);
    check("post_rst_rd_latency", 32'(lat), 32'd3);

    // ACCESS_CYCLES = 1 and 15
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2; i++) begin
        sw_lat[i] = 0; sw_low[i] = 0; sw_done[i] = 1'b0;
      end
      @(negedge CLK50);
      for (int i = 0; i < 2; i++) begin
        if (pass == 0) sw_wr_req[i] = 1'b1;
        else           sw_rd_req[i] = 1'b1;
      end
      for (int k = 1; k <= 30; k++) begin
        @(negedge CLK50);
        for (int i = 0; i < 2; i++) begin
          if (!sw_done[i]) begin
            if (pass == 0 ? !sw_we[i] : !sw_oe[i]) sw_low[i]++;
            if (pass == 0 ? sw_ack[i] : sw_vld[i]) begin
              sw_lat[i] = k; sw_done[i] = 1'b1;
              sw_wr_req[i] = 1'b0; sw_rd_req[i] = 1'b0;
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        check("sw_done", 32'(sw_done[i]), 32'd1);
        check(pass == 0 ? "sw_wr_latency" : "sw_rd_latency", 32'(sw_lat[i]), 32'(sw_ac[i] + 2 - pass));
        check(pass == 0 ? "sw_we_width" : "sw_oe_width", 32'(sw_low[i]), 32'(sw_ac[i]));
      end
    end

    @(negedge CLK50);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("invariant_violations", 32'(inv_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
